// File: rtl/pulse_sequencer_v2.sv
// pulse_sequencer_v2
// Instruction-cycle pulse sequencer: walks P0..P7 (write-back, fetch, addr1,
// addr2, operand move, execute) with run / instruction-step / pulse-step modes,
// stop requests, memory and operation watchdogs with a sticky fault, and a
// retired-instruction counter.
module pulse_sequencer_v2 #(
   parameter int MEM_TIMEOUT = 64,
   parameter int OP_TIMEOUT  = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             do_start,
   input  logic             do_stop,
   input  logic             do_step,
   input  logic             clear_fault,
   input  logic             mem_finish,
   input  logic             operation_finish,
   input  logic             read_addr2,
   input  logic             write_addr2,
   output logic             write_enable,
   output logic             read_enable,
   output logic             start_operation,
   output logic             start_to_select_enable,
   output logic             addr1_to_select_enable,
   output logic             addr2_to_select_enable,
   output logic             mem_to_c_enable,
   output logic             do_start_inc,
   output logic             do_move_c_to_a,
   output logic             do_move_c_to_b,
   output logic [2:0]       cur_pulse,
   output logic             running,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WD_MAX = (OP_TIMEOUT > MEM_TIMEOUT) ? OP_TIMEOUT : MEM_TIMEOUT;
   localparam int WD_W   = $clog2(WD_MAX + 1);
   localparam logic [WD_W-1:0] MEM_LAST = WD_W'(MEM_TIMEOUT - 1);
   localparam logic [WD_W-1:0] OP_LAST  = WD_W'(OP_TIMEOUT - 1);

   // Bit positions inside the entry-strobe vector
   localparam int SB_START = 0;
   localparam int SB_ADDR1 = 1;
   localparam int SB_ADDR2 = 2;
   localparam int SB_MEMC  = 3;
   localparam int SB_INC   = 4;
   localparam int SB_MOVEA = 5;
   localparam int SB_MOVEB = 6;

   typedef enum logic [0:0] {
      ST_ACTIVE = 1'b0,
      ST_FAULT  = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       pulse_reg, pulse_next;
   logic             done_reg, done_next;          // current pulse has finished its work
   logic             wb_reg, wb_next;              // P0 write-back still outstanding
   logic             step_reg, step_next;          // latched do_step (pulse-step mode)
   logic             start_req_reg, start_req_next;// latched do_start while sitting in P0
   logic             running_reg, running_next;
   logic [1:0]       code_reg, code_next;
   logic [WD_W-1:0]  wd_reg, wd_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [6:0]       strobe_reg, strobe_next;

   logic       cont_mode, step_mode, start_go, step_ok;
   logic       ready, mem_wait, op_wait, finish_now;
   logic [2:0] pulse_inc;

   assign cont_mode = (mode == 2'b00) || (mode == 2'b11);
   assign step_mode = (mode == 2'b10);
   assign start_go  = do_start && !do_stop;     // stop wins over a simultaneous start
   assign step_ok   = !step_mode || step_reg || do_step;
   assign pulse_inc = pulse_reg + 3'd1;

   // State register; reset takes effect immediately, independent of the clock
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_ACTIVE;
         pulse_reg     <= 3'd0;
         done_reg      <= 1'b0;
         wb_reg        <= 1'b0;
         step_reg      <= 1'b0;
         start_req_reg <= 1'b0;
         running_reg   <= 1'b0;
         code_reg      <= 2'b00;
         wd_reg        <= '0;
         count_reg     <= '0;
         strobe_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         pulse_reg     <= pulse_next;
         done_reg      <= done_next;
         wb_reg        <= wb_next;
         step_reg      <= step_next;
         start_req_reg <= start_req_next;
         running_reg   <= running_next;
         code_reg      <= code_next;
         wd_reg        <= wd_next;
         count_reg     <= count_next;
         strobe_reg    <= strobe_next;
      end
   end

   // Next-state: pulse completion, advance, watchdog and fault handling
   always_comb begin
      state_next     = state_reg;
      pulse_next     = pulse_reg;
      done_next      = done_reg;
      wb_next        = wb_reg;
      step_next      = step_reg;
      start_req_next = start_req_reg;
      running_next   = running_reg;
      code_next      = code_reg;
      wd_next        = wd_reg;
      count_next     = count_reg;
      strobe_next    = '0;
      ready          = 1'b0;
      mem_wait       = 1'b0;
      op_wait        = 1'b0;
      finish_now     = 1'b0;

      case (state_reg)
         ST_ACTIVE: begin
            if (do_stop)
               running_next = 1'b0;
            else if (do_start)
               running_next = 1'b1;
            if (step_mode && do_step)
               step_next = 1'b1;

            case (pulse_reg)
               3'd0: begin
                  // Write-back first, then wait for a reason to fetch
                  if (wb_reg) begin
                     mem_wait   = 1'b1;
                     finish_now = mem_finish;
                     if (mem_finish)
                        wb_next = 1'b0;
                  end
                  if (start_go)
                     start_req_next = 1'b1;
                  if (do_stop)
                     start_req_next = 1'b0;
                  ready = (!wb_reg || mem_finish) && !do_stop &&
                          (start_req_reg || start_go || (cont_mode && running_reg));
               end
               3'd1, 3'd3: begin
                  mem_wait   = 1'b1;
                  finish_now = mem_finish;
                  ready      = done_reg || mem_finish;
               end
               3'd5: begin
                  if (read_addr2) begin
                     mem_wait   = 1'b1;
                     finish_now = mem_finish;
                     ready      = done_reg || mem_finish;
                  end else begin
                     ready = 1'b1;
                  end
               end
               3'd7: begin
                  op_wait    = 1'b1;
                  finish_now = operation_finish;
                  ready      = done_reg || operation_finish;
               end
               default: ready = 1'b1;
            endcase

            if (ready && step_ok) begin
               pulse_next     = pulse_inc;
               done_next      = 1'b0;
               step_next      = 1'b0;
               start_req_next = 1'b0;
               wd_next        = '0;
               if (pulse_reg == 3'd7) begin
                  count_next = count_reg + CNT_W'(1);
                  wb_next    = write_addr2;
               end
               case (pulse_inc)
                  3'd1: strobe_next[SB_START] = 1'b1;
                  3'd2: begin
                     strobe_next[SB_ADDR1] = 1'b1;
                     strobe_next[SB_MEMC]  = 1'b1;
                  end
                  3'd3: strobe_next[SB_INC] = 1'b1;
                  3'd4: begin
                     strobe_next[SB_ADDR2] = 1'b1;
                     strobe_next[SB_MEMC]  = 1'b1;
                  end
                  3'd5: strobe_next[SB_MOVEA] = 1'b1;
                  3'd6: strobe_next[SB_MEMC]  = read_addr2;
                  3'd7: strobe_next[SB_MOVEB] = read_addr2;
                  default: ;
               endcase
            end else begin
               if (ready)
                  done_next = 1'b1;
               // Only a pulse still waiting on its finish input ages the watchdog;
               // a finish arriving in the last allowed cycle still counts.
               if ((mem_wait || op_wait) && !done_reg && !finish_now) begin
                  if ((mem_wait && wd_reg == MEM_LAST) || (op_wait && wd_reg == OP_LAST)) begin
                     state_next     = ST_FAULT;
                     code_next      = mem_wait ? 2'b01 : 2'b10;
                     running_next   = 1'b0;
                     start_req_next = 1'b0;
                  end else begin
                     wd_next = wd_reg + WD_W'(1);
                  end
               end
            end
         end

         ST_FAULT: begin
            // Everything but clear_fault is ignored; recovery lands halted in P0
            if (clear_fault) begin
               state_next     = ST_ACTIVE;
               pulse_next     = 3'd0;
               code_next      = 2'b00;
               done_next      = 1'b0;
               wb_next        = 1'b0;
               step_next      = 1'b0;
               start_req_next = 1'b0;
               running_next   = 1'b0;
               wd_next        = '0;
            end
         end

         default: state_next = ST_ACTIVE;
      endcase
   end

   logic active;
   assign active = (state_reg == ST_ACTIVE);

   assign cur_pulse       = pulse_reg;
   assign running         = running_reg;
   assign fault           = (state_reg == ST_FAULT);
   assign fault_code      = code_reg;
   assign instr_count     = count_reg;
   assign write_enable    = active && (pulse_reg == 3'd0) && wb_reg;
   assign read_enable     = active && ((pulse_reg == 3'd1) || (pulse_reg == 3'd3) ||
                                       ((pulse_reg == 3'd5) && read_addr2));
   assign start_operation = active && (pulse_reg == 3'd7);

   assign start_to_select_enable = strobe_reg[SB_START];
   assign addr1_to_select_enable = strobe_reg[SB_ADDR1];
   assign addr2_to_select_enable = strobe_reg[SB_ADDR2];
   assign mem_to_c_enable        = strobe_reg[SB_MEMC];
   assign do_start_inc           = strobe_reg[SB_INC];
   assign do_move_c_to_a         = strobe_reg[SB_MOVEA];
   assign do_move_c_to_b         = strobe_reg[SB_MOVEB];

endmodule

// File: tb/tb_pulse_sequencer_v2.sv
// Testbench for pulse_sequencer_v2: randomized instructions checked against a
// per-pulse table of expected strobes and cycle counts, plus directed steps for
// modes, stop, watchdog faults, reset and counter wrap.
module tb_pulse_sequencer_v2;

   localparam int MEM_TO = 8;
   localparam int OP_TO  = 16;
   localparam int CW     = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    mode;
   logic          do_start, do_stop, do_step, clear_fault;
   logic          mem_finish, operation_finish, read_addr2, write_addr2;
   logic          write_enable, read_enable, start_operation;
   logic          start_to_select_enable, addr1_to_select_enable, addr2_to_select_enable;
   logic          mem_to_c_enable, do_start_inc, do_move_c_to_a, do_move_c_to_b;
   logic [2:0]    cur_pulse;
   logic          running, fault;
   logic [1:0]    fault_code;
   logic [CW-1:0] instr_count;

   int n_checks = 0;
   int n_errors = 0;
   int exp_count = 0;
   int n_instr = 0;

   pulse_sequencer_v2 #(.MEM_TIMEOUT(MEM_TO), .OP_TIMEOUT(OP_TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .do_start(do_start), .do_stop(do_stop),
      .do_step(do_step), .clear_fault(clear_fault), .mem_finish(mem_finish),
      .operation_finish(operation_finish), .read_addr2(read_addr2), .write_addr2(write_addr2),
      .write_enable(write_enable), .read_enable(read_enable), .start_operation(start_operation),
      .start_to_select_enable(start_to_select_enable), .addr1_to_select_enable(addr1_to_select_enable),
      .addr2_to_select_enable(addr2_to_select_enable), .mem_to_c_enable(mem_to_c_enable),
      .do_start_inc(do_start_inc), .do_move_c_to_a(do_move_c_to_a), .do_move_c_to_b(do_move_c_to_b),
      .cur_pulse(cur_pulse), .running(running), .fault(fault), .fault_code(fault_code),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // {move_c_to_b, move_c_to_a, start_inc, mem_to_c, addr2_sel, addr1_sel, start_sel}
   function automatic logic [6:0] obs_strobes();
      return {do_move_c_to_b, do_move_c_to_a, do_start_inc, mem_to_c_enable,
              addr2_to_select_enable, addr1_to_select_enable, start_to_select_enable};
   endfunction

   // Entry strobes expected for each pulse
   function automatic logic [6:0] exp_strobes(input int p, input bit r2);
      case (p)
         1: return 7'b0000001;
         2: return 7'b0001010;
         3: return 7'b0010000;
         4: return 7'b0001100;
         5: return 7'b0100000;
         6: return r2 ? 7'b0001000 : 7'b0000000;
         7: return r2 ? 7'b1000000 : 7'b0000000;
         default: return 7'b0000000;
      endcase
   endfunction

   function automatic logic exp_read(input int p, input bit r2);
      return (p == 1) || (p == 3) || ((p == 5) && r2);
   endfunction

   // One full instruction P1..P7 plus the following write-back; memory answers
   // in cycle lm of a memory pulse, the operation unit in cycle lo of P7.
   task automatic run_instr(input bit go, input bit r2, input bit w2, input int lm,
                            input int lo, input int stop_at);
      int k, cyc, guard, p_prev, exp_cyc, j;
      read_addr2  = r2;
      write_addr2 = w2;
      if (go) do_start = 1'b1;
      guard = 0;
      while (cur_pulse == 3'd0 && guard < 50) begin
         tick();
         do_start = 1'b0;
         guard++;
      end
      do_start = 1'b0;
      chk("leave_p0", 32'(cur_pulse), 32'd1);
      p_prev = 0; k = 0; cyc = 0; guard = 0;
      while (guard < 200) begin
         if (int'(cur_pulse) != p_prev) begin
            k = 1;
            p_prev = int'(cur_pulse);
            chk("strobe_entry", 32'(obs_strobes()), 32'(exp_strobes(p_prev, r2)));
            if (p_prev == 0) break;
            chk("read_enable", 32'(read_enable), 32'(exp_read(p_prev, r2)));
            chk("start_operation", 32'(start_operation), 32'(p_prev == 7));
         end else begin
            k++;
            chk("strobe_idle", 32'(obs_strobes()), 32'd0);
         end
         do_stop          = (stop_at != 0) && (k == 1) && (p_prev == stop_at);
         mem_finish       = read_enable && (k == lm);
         operation_finish = start_operation && (k == lo);
         cyc++;
         tick();
         guard++;
      end
      do_stop = 1'b0; mem_finish = 1'b0; operation_finish = 1'b0;
      chk("reached_p0", 32'(cur_pulse), 32'd0);
      exp_cyc = lm + 1 + lm + 1 + (r2 ? lm : 1) + 1 + lo;
      chk("instr_cycles", 32'(cyc), 32'(exp_cyc));
      exp_count = (exp_count + 1) % (1 << CW);
      chk("instr_count", 32'(instr_count), 32'(exp_count));
      chk("wb_level", 32'(write_enable), 32'(w2));
      if (w2) begin
         j = 0;
         while (write_enable && j < 20) begin
            j++;
            mem_finish = (j == lm);
            tick();
         end
         mem_finish = 1'b0;
         chk("wb_cycles", 32'(j), 32'(lm));
      end
      n_instr++;
      $display("instr %0d: r2=%0d w2=%0d lm=%0d lo=%0d cycles=%0d count=%0d",
               n_instr, r2, w2, lm, lo, cyc, instr_count);
   endtask

   // Drive an instruction up to pulse 'target', then starve it until the watchdog trips
   task automatic wait_fault(input int target, input int timeout, input int code);
      int guard, n;
      read_addr2  = 1'b1;
      write_addr2 = 1'b0;
      do_start    = 1'b1;
      guard = 0;
      while (int'(cur_pulse) != target && guard < 100) begin
         mem_finish       = read_enable;
         operation_finish = start_operation;
         tick();
         do_start = 1'b0;
         guard++;
      end
      mem_finish = 1'b0; operation_finish = 1'b0; do_start = 1'b0;
      n = 0;
      while (!fault && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'(timeout));
      chk("fault", 32'(fault), 32'd1);
      chk("fault_code", 32'(fault_code), 32'(code));
      chk("fault_pulse", 32'(cur_pulse), 32'(target));
      chk("fault_outputs", 32'({read_enable, write_enable, start_operation, running}), 32'd0);
      // Inputs other than clear_fault have no effect while faulted
      do_start = 1'b1; do_step = 1'b1; mem_finish = 1'b1; operation_finish = 1'b1;
      tick();
      do_start = 1'b0; do_step = 1'b0; mem_finish = 1'b0; operation_finish = 1'b0;
      tick();
      chk("fault_sticky", 32'(fault), 32'd1);
      chk("fault_frozen", 32'(cur_pulse), 32'(target));
      $display("fault at P%0d code=%0d after %0d cycles", cur_pulse, fault_code, n);
      clear_fault = 1'b1; do_start = 1'b1;
      tick();
      clear_fault = 1'b0; do_start = 1'b0;
      chk("clear_fault", 32'(fault), 32'd0);
      chk("clear_code", 32'(fault_code), 32'd0);
      chk("clear_pulse", 32'(cur_pulse), 32'd0);
      tick(); tick();
      chk("clear_halted", 32'(cur_pulse), 32'd0);
      chk("clear_running", 32'(running), 32'd0);
   endtask

   initial begin
      bit r2, w2;
      int lm, lo;
      reset = 1'b1; mode = 2'b01;
      do_start = 1'b0; do_stop = 1'b0; do_step = 1'b0; clear_fault = 1'b0;
      mem_finish = 1'b0; operation_finish = 1'b0; read_addr2 = 1'b0; write_addr2 = 1'b0;
      tick(); tick();
      chk("rst_pulse", 32'(cur_pulse), 32'd0);
      chk("rst_flags", 32'({running, fault, fault_code}), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_strobes", 32'(obs_strobes()), 32'd0);
      chk("rst_enables", 32'({read_enable, write_enable, start_operation}), 32'd0);
      reset = 1'b0;
      tick();

      // Instruction-step mode with random instruction shapes and latencies
      mode = 2'b01;
      repeat (20) begin
         r2 = 1'($urandom_range(0, 1));
         w2 = 1'($urandom_range(0, 1));
         lm = int'($urandom_range(1, MEM_TO));
         lo = int'($urandom_range(1, OP_TO));
         run_instr(1'b1, r2, w2, lm, lo, 0);
         tick(); tick();
         chk("step_halted", 32'(cur_pulse), 32'd0);
      end

      // Continuous mode: back-to-back, then stop requested in P4
      do_stop = 1'b1; tick(); do_stop = 1'b0;
      mode = 2'b00;
      run_instr(1'b1, 1'b1, 1'b0, 3, 5, 0);
      chk("cont_running", 32'(running), 32'd1);
      run_instr(1'b0, 1'b1, 1'b1, 3, 5, 4);
      tick(); tick(); tick();
      chk("stop_halted", 32'(cur_pulse), 32'd0);
      chk("stop_running", 32'(running), 32'd0);

      // Start and stop together: stop wins
      do_start = 1'b1; do_stop = 1'b1;
      tick();
      do_start = 1'b0; do_stop = 1'b0;
      tick(); tick();
      chk("startstop_pulse", 32'(cur_pulse), 32'd0);
      chk("startstop_running", 32'(running), 32'd0);

      // Pulse-step mode: one pulse per do_step, nothing in between
      mode = 2'b10; mem_finish = 1'b1; operation_finish = 1'b1;
      read_addr2 = 1'b1; write_addr2 = 1'b0;
      do_start = 1'b1; tick(); do_start = 1'b0;
      tick(); tick();
      chk("pstep_wait", 32'(cur_pulse), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         do_step = 1'b1;
         tick();
         do_step = 1'b0;
         chk("pstep_adv", 32'(cur_pulse), 32'(i % 8));
         repeat ((i == 3) ? 12 : 2) tick();
         chk("pstep_hold", 32'(cur_pulse), 32'(i % 8));
         chk("pstep_nofault", 32'(fault), 32'd0);
      end
      exp_count = (exp_count + 1) % (1 << CW);
      chk("pstep_count", 32'(instr_count), 32'(exp_count));
      mem_finish = 1'b0; operation_finish = 1'b0;

      // Watchdogs
      mode = 2'b01;
      wait_fault(3, MEM_TO, 1);
      wait_fault(7, OP_TO, 2);

      // Asynchronous reset while waiting in P5
      read_addr2 = 1'b1; write_addr2 = 1'b0; do_start = 1'b1;
      for (int g = 0; g < 40 && cur_pulse != 3'd5; g++) begin
         mem_finish = read_enable;
         operation_finish = start_operation;
         tick();
         do_start = 1'b0;
      end
      mem_finish = 1'b0; operation_finish = 1'b0; do_start = 1'b0;
      chk("pre_reset_p5", 32'({cur_pulse, read_enable}), 32'({3'd5, 1'b1}));
      reset = 1'b1;
      #1;
      chk("areset_pulse", 32'(cur_pulse), 32'd0);
      chk("areset_enables", 32'({read_enable, write_enable, start_operation}), 32'd0);
      chk("areset_state", 32'({running, fault, fault_code, obs_strobes()}), 32'd0);
      chk("areset_count", 32'(instr_count), 32'd0);
      reset = 1'b0;
      exp_count = 0;
      tick();

      // Exactly 2^CNT_W instructions bring the counter back to zero
      repeat (1 << CW) begin
         r2 = 1'($urandom_range(0, 1));
         lm = int'($urandom_range(1, 4));
         lo = int'($urandom_range(1, 6));
         run_instr(1'b1, r2, 1'b0, lm, lo, 0);
      end
      chk("count_wrap", 32'(instr_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
